adc_window_comp: RTL and testbench
==================================

# adc_window_comp

Parametrised successor to the single-threshold ADC comparator. Decimates the ADC sample stream, averages a window of 2^AVG_LOG2 decimated samples, and compares the average against a threshold with optional hysteresis. Sits between the ADC capture interface and the PLL/SWIPT control logic. Produces a level output, a one-cycle decision strobe, a change strobe and the averaged value for monitoring.

## Interface
Parameters:
- ADC_W, 12, ADC sample width in bits.
- DECIM, 400, clock cycles between sample strobes; must be ≥1.
- AVG_LOG2, 2, log2 of the number of strobed samples averaged per decision; must be 0..8.
- THRESH, 2**(ADC_W-1), decision threshold (midscale).
- HYST, 16, hysteresis half-band. Elaboration must error unless HYST ≤ THRESH and THRESH+HYST ≤ 2**ADC_W-1.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- en  in  1  block enable (swiptAlive); low clears all state, as reset does.
- adc  in  ADC_W  raw ADC sample.
- comp  out  1  1 = averaged input below threshold.
- comp_valid  out  1  one-cycle pulse per completed window.
- comp_chg  out  1  one-cycle pulse when comp toggles.
- avg  out  ADC_W  last window average.

## Operation
- adc is registered into adc_q every cycle, regardless of en. adc_q resets to 0.
- Clear condition: nrst low or en low. While it holds:
  - dec_cnt, samp_cnt and acc go to 0.
  - comp, comp_valid, comp_chg and avg go to 0.
- States:
  - IDLE: clear condition true.
  - RUN: clear condition false. RUN → IDLE on any clear.
- In RUN, dec_cnt counts down. A strobe occurs when dec_cnt == 0, and dec_cnt then reloads DECIM-1. The first strobe occurs on the first RUN cycle.
- On a strobe that is not the last of the window: acc += adc_q and samp_cnt++. acc is ADC_W+AVG_LOG2 bits wide and never overflows.
- On the last strobe (samp_cnt == 2^AVG_LOG2-1):
  - Compute sum = acc + adc_q and avg_n = sum >> AVG_LOG2 (truncating).
  - Register avg <= avg_n and apply the decision rule to avg_n.
  - Pulse comp_valid; pulse comp_chg if comp changed.
  - Clear acc and samp_cnt.
- Decision rule with hysteresis:
  - Set comp when avg_n < THRESH-HYST.
  - Clear comp when avg_n ≥ THRESH+HYST.
  - Otherwise hold comp.
- A partial window is discarded when en drops or nrst asserts. The next window starts fresh.

## Timing
- Each window spans (2^AVG_LOG2-1)·DECIM+1 clock cycles from the first strobe to the last strobe.
- avg, comp, comp_valid and comp_chg update on the last strobe's edge. The sample used at that strobe was presented on adc one cycle earlier.
- comp_valid and comp_chg are high for exactly one cycle. With DECIM=1, AVG_LOG2=0, comp_valid is high every RUN cycle.
- Reset or en drop on the same edge as a last strobe: clear wins; no valid pulse is produced.
- The first window after reset or enable compares against comp=0.

## Configuration
- ADC_COMP_HYST_EN defined: hysteresis rule as described in Operation.
- ADC_COMP_HYST_EN undefined: HYST is ignored, and comp <= (avg_n < THRESH) on every decision. comp never holds its previous value.

## Structure
- Shared package adc_comp_pkg holds:
  - the state enum (IDLE, RUN);
  - the function computing the accumulator width;
  - the default THRESH/HYST constants.
- One sub-module, adc_decimator, generates the strobe and owns dec_cnt.
- The top level holds accumulator, averaging and decision logic.

## Test plan
All scenarios use ADC_W=12, DECIM=4, AVG_LOG2=2, THRESH=0x800, HYST=0x10, macro defined unless stated.
- Reset: nrst=0 for 3 cycles with adc=0xFFF → comp, comp_valid, comp_chg and avg all 0 the following cycle.
- Set: en=1, adc constant 0x700 → after 13 cycles comp_valid pulses, avg=0x700, comp=1, comp_chg pulses. Then adc=0x900 → next window gives comp=0 and a comp_chg pulse.
- Hysteresis: from comp=1, adc=0x805 → avg=0x805, comp stays 1, no comp_chg. Then adc=0x810 → comp=0. With macro undefined, 0x805 alone gives comp=0.
- Averaging: strobed samples 0x100, 0x200, 0x300, 0x400 → avg=0x280, comp=1. Strobed samples 0xFFF×4 → avg=0xFFF with no overflow.
- Enable abort: en low after 2 strobes → no comp_valid. On re-enable, next comp_valid follows 4 fresh strobes, and avg excludes the stale samples.
- Mid-run reset: comp=1, nrst=0 for 1 cycle coinciding with a last strobe → comp=0, no comp_valid. Operation restarts cleanly.

Source files
------------

// File: rtl/adc_comp_pkg.sv
// ---------------------------------------------------------------------------
// adc_comp_pkg
// Shared types and constants for the ADC window comparator.
//   state_e    : block state (IDLE while cleared, RUN while counting)
//   acc_width  : accumulator width needed to sum 2^avg_log2 samples
//   mid_scale  : default decision threshold for a given sample width
//   DEF_ADC_W / DEF_HYST : default sample width and hysteresis half-band
// ---------------------------------------------------------------------------
package adc_comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_ADC_W = 12;
    localparam int unsigned DEF_HYST  = 16;

    // Summing 2^avg_log2 values of adc_w bits needs avg_log2 extra bits.
    function automatic int unsigned acc_width(input int unsigned adc_w,
                                              input int unsigned avg_log2);
        return adc_w + avg_log2;
    endfunction

    function automatic int unsigned mid_scale(input int unsigned adc_w);
        return 32'd1 << (adc_w - 1);
    endfunction

endpackage

// File: rtl/adc_window_comp_if.sv
// ---------------------------------------------------------------------------
// adc_window_comp_if
// Sample input and decision outputs of the ADC window comparator.
//   en         : block enable (low clears the comparator)
//   adc        : raw ADC sample
//   comp       : 1 = averaged input below threshold
//   comp_valid : one-cycle pulse per completed window
//   comp_chg   : one-cycle pulse when comp toggles
//   avg        : last window average
// Modports: master drives en/adc, slave (the comparator) drives the results.
// ---------------------------------------------------------------------------
interface adc_window_comp_if
    import adc_comp_pkg::*;
#(
    parameter int unsigned ADC_W = DEF_ADC_W
) ();

    logic             en;
    logic [ADC_W-1:0] adc;
    logic             comp;
    logic             comp_valid;
    logic             comp_chg;
    logic [ADC_W-1:0] avg;

    modport master (
        output en,
        output adc,
        input  comp,
        input  comp_valid,
        input  comp_chg,
        input  avg
    );

    modport slave (
        input  en,
        input  adc,
        output comp,
        output comp_valid,
        output comp_chg,
        output avg
    );

endinterface

// File: rtl/adc_decimator.sv
// ---------------------------------------------------------------------------
// adc_decimator
// Generates the sample strobe: one pulse every DECIM cycles while running,
// the first on the very first running cycle.
//   clk      : clock
//   i_run    : 1 = counting; 0 = hold the counter cleared
//   o_strobe : sample strobe
// ---------------------------------------------------------------------------
module adc_decimator #(
    parameter int unsigned DECIM = 400
) (
    input  logic clk,
    input  logic i_run,
    output logic o_strobe
);

    localparam int unsigned       CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] w_dec_cnt_nxt;

    // Counter sits at zero while cleared, so the first running cycle strobes.
    assign o_strobe = i_run && (r_dec_cnt == '0);

    always_comb begin
        w_dec_cnt_nxt = r_dec_cnt;
        if (!i_run) begin
            w_dec_cnt_nxt = '0;
        end else if (o_strobe) begin
            w_dec_cnt_nxt = RELOAD;
        end else begin
            w_dec_cnt_nxt = r_dec_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_dec_cnt <= w_dec_cnt_nxt;
    end

endmodule

// File: rtl/adc_window_comp.sv
// ---------------------------------------------------------------------------
// adc_window_comp
// Decimates the ADC stream, averages 2^AVG_LOG2 strobed samples and compares
// the average against THRESH, optionally with a +/-HYST hysteresis band.
//   clk  : clock
//   nrst : synchronous active-low reset
//   bus  : adc_window_comp_if.slave (en, adc in; comp, comp_valid,
//          comp_chg, avg out)
// Build option: define ADC_COMP_HYST_EN to enable the hysteresis rule;
// otherwise comp is simply (avg < THRESH) on every decision.
// ---------------------------------------------------------------------------
module adc_window_comp
    import adc_comp_pkg::*;
#(
    parameter int unsigned ADC_W    = DEF_ADC_W,
    parameter int unsigned DECIM    = 400,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned THRESH   = mid_scale(ADC_W),
    parameter int unsigned HYST     = DEF_HYST
) (
    input logic              clk,
    input logic              nrst,
    adc_window_comp_if.slave bus
);

    localparam int unsigned      ACC_W   = acc_width(ADC_W, AVG_LOG2);
    localparam int unsigned      SC_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SC_W-1:0]  LAST_IX = SC_W'((32'd1 << AVG_LOG2) - 1);
    localparam longint unsigned  ADC_MAX = (64'd1 << ADC_W) - 64'd1;

    // Parameter sanity checks, evaluated at elaboration.
    if (DECIM < 1) begin : g_bad_decim
        $error("adc_window_comp: DECIM must be >= 1");
    end
    if (AVG_LOG2 > 8) begin : g_bad_avg
        $error("adc_window_comp: AVG_LOG2 must be 0..8");
    end
    if ((HYST > THRESH) || (64'(THRESH) + 64'(HYST) > ADC_MAX)) begin : g_bad_hyst
        $error("adc_window_comp: need HYST <= THRESH and THRESH+HYST <= 2**ADC_W-1");
    end

`ifdef ADC_COMP_HYST_EN
    localparam logic [ADC_W-1:0] SET_BELOW = ADC_W'(THRESH - HYST);
    localparam logic [ADC_W-1:0] CLR_AT    = ADC_W'(THRESH + HYST);
`else
    localparam logic [ADC_W-1:0] TH        = ADC_W'(THRESH);
`endif

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_clear;
    logic             w_run;
    logic             w_strobe;
    logic             w_last;

    logic [ADC_W-1:0] r_adc_q;
    logic [ACC_W-1:0] r_acc;
    logic [SC_W-1:0]  r_samp_cnt;
    logic             r_comp;
    logic             r_comp_valid;
    logic             r_comp_chg;
    logic [ADC_W-1:0] r_avg;

    logic [ACC_W-1:0] w_sum;
    logic [ADC_W-1:0] w_avg_n;
    logic             w_comp_n;

    assign w_clear = !nrst || !bus.en;

    // ---- state machine ----------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_run is Mealy so the first strobe lands on the first enabled edge.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_clear) begin
                    w_state_nxt = RUN;
                    w_run       = 1'b1;
                end
            end
            RUN: begin
                if (w_clear) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    adc_decimator #(
        .DECIM (DECIM)
    ) u_decim (
        .clk      (clk),
        .i_run    (w_run),
        .o_strobe (w_strobe)
    );

    // ---- averaging and decision -------------------------------------------
    always_comb begin
        w_last   = w_strobe && (r_samp_cnt == LAST_IX);
        w_sum    = r_acc + ACC_W'(r_adc_q);
        w_avg_n  = ADC_W'(w_sum >> AVG_LOG2);
        w_comp_n = r_comp;
`ifdef ADC_COMP_HYST_EN
        if (w_avg_n < SET_BELOW) begin
            w_comp_n = 1'b1;
        end else if (w_avg_n >= CLR_AT) begin
            w_comp_n = 1'b0;
        end
`else
        w_comp_n = (w_avg_n < TH);
`endif
    end

    // Sample register ignores en; only reset clears it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_adc_q <= '0;
        end else begin
            r_adc_q <= bus.adc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_acc        <= '0;
            r_samp_cnt   <= '0;
            r_comp       <= 1'b0;
            r_comp_valid <= 1'b0;
            r_comp_chg   <= 1'b0;
            r_avg        <= '0;
        end else begin
            r_comp_valid <= w_last;
            r_comp_chg   <= w_last && (w_comp_n != r_comp);
            if (w_last) begin
                r_avg      <= w_avg_n;
                r_comp     <= w_comp_n;
                r_acc      <= '0;
                r_samp_cnt <= '0;
            end else if (w_strobe) begin
                r_acc      <= w_sum;
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
        end
    end

    assign bus.comp       = r_comp;
    assign bus.comp_valid = r_comp_valid;
    assign bus.comp_chg   = r_comp_chg;
    assign bus.avg        = r_avg;

endmodule

// File: tb/tb_adc_window_comp.sv
// ---------------------------------------------------------------------------
// tb_adc_window_comp
// Bench for adc_window_comp with ADC_W=12, DECIM=4, AVG_LOG2=2,
// THRESH=0x800, HYST=0x10. Expectations follow ADC_COMP_HYST_EN as built.
// ---------------------------------------------------------------------------
module tb_adc_window_comp;
    import adc_comp_pkg::*;

    localparam int unsigned ADC_W    = 12;
    localparam int unsigned DECIM    = 4;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned THRESH   = 'h800;
    localparam int unsigned HYST     = 'h10;
    localparam int unsigned NWIN     = 1 << AVG_LOG2;
`ifdef ADC_COMP_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;

    adc_window_comp_if #(.ADC_W(ADC_W)) bus ();

    adc_window_comp #(
        .ADC_W    (ADC_W),
        .DECIM    (DECIM),
        .AVG_LOG2 (AVG_LOG2),
        .THRESH   (THRESH),
        .HYST     (HYST)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---- reference model: counts run cycles, keeps strobed samples in a queue
    int unsigned m_run   = 0;
    int unsigned m_win[$];
    int unsigned m_adc_q = 0;
    bit          m_comp  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_chg   = 1'b0;
    int unsigned m_avg   = 0;

    function automatic void model_edge(bit rst_n, bit en, int unsigned a);
        int unsigned sum;
        bit          nc;
        if (!rst_n || !en) begin
            m_run   = 0;
            m_win.delete();
            m_comp  = 1'b0;
            m_valid = 1'b0;
            m_chg   = 1'b0;
            m_avg   = 0;
        end else begin
            m_valid = 1'b0;
            m_chg   = 1'b0;
            if (m_run % DECIM == 0) begin
                m_win.push_back(m_adc_q);
                if (m_win.size() == NWIN) begin
                    sum = 0;
                    foreach (m_win[i]) sum += m_win[i];
                    m_avg = sum / NWIN;
                    if (HYST_ON) begin
                        if (m_avg < THRESH - HYST)       nc = 1'b1;
                        else if (m_avg >= THRESH + HYST) nc = 1'b0;
                        else                             nc = m_comp;
                    end else begin
                        nc = (m_avg < THRESH);
                    end
                    m_valid = 1'b1;
                    m_chg   = (nc != m_comp);
                    m_comp  = nc;
                    m_win.delete();
                end
            end
            m_run++;
        end
        m_adc_q = rst_n ? a : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // One clock edge with the given inputs; DUT compared with the model after it.
    task automatic step(input bit rst_n, input bit en, input logic [11:0] a);
        nrst    = rst_n;
        bus.en  = en;
        bus.adc = a;
        @(posedge clk);
        model_edge(rst_n, en, a);
        cyc++;
        #1;
        check("model.comp",       32'(bus.comp),       32'(m_comp));
        check("model.comp_valid", 32'(bus.comp_valid), 32'(m_valid));
        check("model.comp_chg",   32'(bus.comp_chg),   32'(m_chg));
        check("model.avg",        32'(bus.avg),        m_avg);
    endtask

    typedef struct {
        string       name;
        bit          rst_n;
        bit          en;
        logic [11:0] adc;
        int          cycles;
        bit          comp;
        bit          valid;
        bit          chg;
        logic [11:0] avg;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string name, input bit rst_n, input bit en,
                                input logic [11:0] adc, input int cycles, input bit comp,
                                input bit valid, input bit chg, input logic [11:0] avg);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.en = en; v.adc = adc; v.cycles = cycles;
        v.comp = comp; v.valid = valid; v.chg = chg; v.avg = avg;
        tbl.push_back(v);
    endfunction

    initial begin
        nrst    = 1'b0;
        bus.en  = 1'b0;
        bus.adc = '0;

        //   name           rst en adc     cyc comp val chg avg
        add("reset",        0, 0, 12'hFFF, 3,  0, 0, 0, 12'h000);
        add("idle",         1, 0, 12'h700, 1,  0, 0, 0, 12'h000);
        add("set_fill",     1, 1, 12'h700, 12, 0, 0, 0, 12'h000);
        add("set_win",      1, 1, 12'h700, 1,  1, 1, 1, 12'h700);
        add("set_after",    1, 1, 12'h700, 1,  1, 0, 0, 12'h700);
        add("hi_fill",      1, 1, 12'h900, 14, 1, 0, 0, 12'h700);
        add("hi_win",       1, 1, 12'h900, 1,  0, 1, 1, 12'h900);
        add("lo_again",     1, 1, 12'h700, 16, 1, 1, 1, 12'h700);
        add("in_band",      1, 1, 12'h805, 16, HYST_ON, 1, !HYST_ON, 12'h805);
        add("band_edge",    1, 1, 12'h810, 16, 0, 1, HYST_ON, 12'h810);
        add("avg_s100",     1, 1, 12'h100, 4,  0, 0, 0, 12'h810);
        add("avg_s200",     1, 1, 12'h200, 4,  0, 0, 0, 12'h810);
        add("avg_s300",     1, 1, 12'h300, 4,  0, 0, 0, 12'h810);
        add("avg_s400",     1, 1, 12'h400, 4,  1, 1, 1, 12'h280);
        add("full_scale",   1, 1, 12'hFFF, 16, 0, 1, 1, 12'hFFF);
        add("part_a",       1, 1, 12'h100, 3,  0, 0, 0, 12'hFFF);
        add("part_b",       1, 1, 12'h100, 8,  0, 0, 0, 12'hFFF);
        add("en_abort",     1, 0, 12'h600, 2,  0, 0, 0, 12'h000);
        add("re_fill",      1, 1, 12'h600, 12, 0, 0, 0, 12'h000);
        add("re_win",       1, 1, 12'h600, 1,  1, 1, 1, 12'h600);
        add("pre_rst",      1, 1, 12'h600, 15, 1, 0, 0, 12'h600);
        add("rst_on_last",  0, 1, 12'h600, 1,  0, 0, 0, 12'h000);
        add("idle2",        1, 0, 12'h900, 1,  0, 0, 0, 12'h000);
        add("restart_fill", 1, 1, 12'h900, 12, 0, 0, 0, 12'h000);
        add("restart_win",  1, 1, 12'h900, 1,  0, 1, 0, 12'h900);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].cycles; k++) begin
                step(tbl[i].rst_n, tbl[i].en, tbl[i].adc);
            end
            check({tbl[i].name, ".comp"},       32'(bus.comp),       32'(tbl[i].comp));
            check({tbl[i].name, ".comp_valid"}, 32'(bus.comp_valid), 32'(tbl[i].valid));
            check({tbl[i].name, ".comp_chg"},   32'(bus.comp_chg),   32'(tbl[i].chg));
            check({tbl[i].name, ".avg"},        32'(bus.avg),        32'(tbl[i].avg));
        end

        // Randomised run, samples biased around the hysteresis band.
        for (int n = 0; n < 3000; n++) begin
            bit          r_n;
            bit          e;
            logic [11:0] a;
            r_n = ($urandom_range(0, 199) != 0);
            e   = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(0, 4095));
            else                           a = 12'(THRESH - 'h20 + $urandom_range(0, 'h40));
            step(r_n, e, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
